piece_spawner: RTL and testbench
================================

# piece_spawner

Parametrised successor to the fixed 20×10 block generator. It places one of seven tetromino shapes at the top of a playfield held in an external synchronous RAM. Before writing, it checks every target cell for collision; any occupied cell raises a sticky game-over flag instead of writing. It sits between the game-control FSM, which issues spawn requests, and the playfield RAM, which it accesses through one read port and one write port.

## Interface
- ROWS, 20, playfield height in cells (≥ 2)
- COLS, 10, playfield width in cells (≥ SPAWN_COL+4)
- SPAWN_COL, 3, leftmost column of a piece's bounding box at spawn
- CELL_W, 3, bits per cell; 0 = empty, nonzero = occupied (written value = piece id)
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- spawn_req  in  1  request pulse; sampled only in IDLE
- piece_id  in  3  shape select 1..7; captured when the request is accepted
- busy  out  1  high from the cycle after acceptance through the done cycle
- done  out  1  one-cycle pulse at the end of each accepted request
- game_over  out  1  sticky collision flag; cleared only by reset
- rd_row  out  $clog2(ROWS)  read address, row
- rd_col  out  $clog2(COLS)  read address, column
- rd_data  in  CELL_W  RAM read data, valid one cycle after the address
- wr_en  out  1  write strobe
- wr_row  out  $clog2(ROWS)  write address, row
- wr_col  out  $clog2(COLS)  write address, column
- wr_data  out  CELL_W  write data

## Operation
- Shape table, as (row, col-offset from SPAWN_COL):
  - 1 I: (0,0)(0,1)(0,2)(0,3)
  - 2 J: (0,0)(1,0)(1,1)(1,2)
  - 3 L: (0,2)(1,0)(1,1)(1,2)
  - 4 O: (0,1)(0,2)(1,1)(1,2)
  - 5 S: (0,1)(0,2)(1,0)(1,1)
  - 6 T: (0,1)(1,0)(1,1)(1,2)
  - 7 Z: (0,0)(0,1)(1,1)(1,2)
- FSM states and transitions:
  - IDLE → CHECK on spawn_req when game_over=0. Latch piece_id.
  - CHECK: issue cell k=0..3 reads on consecutive cycles; test each rd_data as it returns. Any nonzero sets a collision bit.
  - After the 4th datum: collision → OVER, else → WRITE.
  - WRITE: assert wr_en for cells 0..3 on 4 consecutive cycles with wr_data = latched id → DONE.
  - OVER: set game_over → DONE. No writes.
  - DONE: pulse done → IDLE.
- Invalid id (0): IDLE → DONE directly. No reads, no writes, game_over unchanged.
- spawn_req while busy, or while game_over=1: ignored, no done.
- Cell order k is the table order above, for both reads and writes.
- Reset values: busy, done, game_over, wr_en = 0; all address and data outputs = 0.
- Reset mid-operation:
  - FSM returns to IDLE asynchronously.
  - wr_en drops immediately; partially written cells are not rolled back.

## Timing
- Acceptance cycle = T.
- rd addresses are driven at T+1..T+4; data is tested at T+2..T+5.
- Success path:
  - wr_en is high at T+6..T+9.
  - done pulses at T+10.
  - busy is high T+1..T+10.
  - The next request is accepted at T+11 at the earliest.
- Collision path:
  - game_over rises at T+6 and holds.
  - done pulses at T+7, with game_over=1 in that cycle.
- Invalid id: done pulses at T+1, busy high at T+1 only.
- Outputs are registered; rd_* and wr_* hold their last values when inactive.

## Structure
- Shared package `tetris_pkg`:
  - piece-id constants PIECE_I..PIECE_Z
  - the shape-offset table as a function returning (row, coloff) for (id, k)
  - FSM state encoding
- Parameter legality is checked at elaboration: fatal if COLS < SPAWN_COL+4 or ROWS < 2.
- Natural sub-module: `shape_rom`, combinational (id, k) → (row, col), reused later by the rotate/move logic.
- The top-level `game` instantiates the spawner with ROWS=20, COLS=10, and clocks it from CLK_50.

## Test plan
- Empty field, id=1, SPAWN_COL=3 → writes (0,3)(0,4)(0,5)(0,6) with data 1 at T+6..T+9; done at T+10; game_over=0.
- Empty field, id=6 → writes (0,4)(1,3)(1,4)(1,5) with data 6; a second request at T+5 is ignored (no extra done).
- Preload (1,4)=2, id=4 → no wr_en at all; game_over=1 at T+6, done at T+7; a later spawn_req produces no activity.
- id=0 → done at T+1, no reads, no writes, game_over=0.
- resetn low at T+7 during an id=2 write → busy, wr_en, game_over = 0 immediately; a new id=7 request is fully processed after release.
- ROWS=8, COLS=6, SPAWN_COL=1, id=3 → writes (0,3)(1,1)(1,2)(1,3), address widths 3 and 3.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetromino logic.
// - PIECE_* : piece identifiers (0 = no piece / invalid request)
// - state_t : spawner FSM state encoding, also exported for debug
// - cell_off_t / shape_cell() : the spawn shape table, giving the
//   (row, column offset) of cell k (0..3) of a piece. Cells are listed in
//   raster order (row 0 left to right, then row 1), which is also the order
//   in which the spawner reads and writes them.
package tetris_pkg;

    localparam logic [2:0] PIECE_NONE = 3'd0;
    localparam logic [2:0] PIECE_I    = 3'd1;
    localparam logic [2:0] PIECE_J    = 3'd2;
    localparam logic [2:0] PIECE_L    = 3'd3;
    localparam logic [2:0] PIECE_O    = 3'd4;
    localparam logic [2:0] PIECE_S    = 3'd5;
    localparam logic [2:0] PIECE_T    = 3'd6;
    localparam logic [2:0] PIECE_Z    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WRITE = 3'd2,
        ST_OVER  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic       row;     // 0 or 1: every piece spawns within two rows
        logic [1:0] coloff;  // 0..3 from the spawn column
    } cell_off_t;

    // Each shape is packed as {cell3, cell2, cell1, cell0}, 3 bits per cell
    // laid out as {row, coloff}.
    function automatic cell_off_t shape_cell(input logic [2:0] id, input logic [1:0] k);
        logic [11:0] tbl;
        case (id)
            PIECE_I: tbl = {3'b011, 3'b010, 3'b001, 3'b000};
            PIECE_J: tbl = {3'b110, 3'b101, 3'b100, 3'b000};
            PIECE_L: tbl = {3'b110, 3'b101, 3'b100, 3'b010};
            PIECE_O: tbl = {3'b110, 3'b101, 3'b010, 3'b001};
            PIECE_S: tbl = {3'b101, 3'b100, 3'b010, 3'b001};
            PIECE_T: tbl = {3'b110, 3'b101, 3'b100, 3'b001};
            PIECE_Z: tbl = {3'b110, 3'b101, 3'b001, 3'b000};
            default: tbl = 12'd0;
        endcase
        return cell_off_t'(tbl[int'(k) * 3 +: 3]);
    endfunction

endpackage

// File: rtl/piece_spawner_if.sv
// Bundle between the spawner, the game-control FSM and the playfield RAM.
// - spawn_req/piece_id : request from game control
// - busy/done/game_over: status back to game control
// - rd_row/rd_col/rd_data : RAM read port (data one cycle after address)
// - wr_en/wr_row/wr_col/wr_data : RAM write port
//
// Handshake: spawn_req is a single-cycle request with no ready return. It is
// taken only in a cycle where the spawner is idle (busy low) and game_over is
// low; piece_id is captured in that same cycle. Requests in any other cycle
// are dropped without a response. Every taken request produces exactly one
// done pulse, and busy stays high from the cycle after acceptance up to and
// including the done cycle.
interface piece_spawner_if #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 3
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic              spawn_req;
    logic [2:0]        piece_id;
    logic              busy;
    logic              done;
    logic              game_over;
    logic [RW-1:0]     rd_row;
    logic [CW-1:0]     rd_col;
    logic [CELL_W-1:0] rd_data;
    logic              wr_en;
    logic [RW-1:0]     wr_row;
    logic [CW-1:0]     wr_col;
    logic [CELL_W-1:0] wr_data;

    // Environment side: game control plus playfield RAM.
    modport master (
        output spawn_req, piece_id, rd_data,
        input  busy, done, game_over, rd_row, rd_col,
        input  wr_en, wr_row, wr_col, wr_data
    );

    // Spawner side.
    modport slave (
        input  spawn_req, piece_id, rd_data,
        output busy, done, game_over, rd_row, rd_col,
        output wr_en, wr_row, wr_col, wr_data
    );
endinterface

// File: rtl/piece_spawner_shape_rom.sv
// shape_rom: combinational lookup of absolute playfield coordinates for
// cell k of piece id placed with its bounding box at (0, SPAWN_COL).
// Ports:
//   id  in  piece id (1..7; 0 yields the origin)
//   k   in  cell index 0..3
//   row out playfield row
//   col out playfield column
module shape_rom
    import tetris_pkg::*;
#(
    parameter  int ROWS      = 20,
    parameter  int COLS      = 10,
    parameter  int SPAWN_COL = 3,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS)
) (
    input  logic [2:0]    id,
    input  logic [1:0]    k,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col
);

    cell_off_t off;

    always_comb begin
        off = shape_cell(id, k);
        row = RW'(off.row);
        col = CW'(SPAWN_COL) + CW'(off.coloff);
    end

endmodule

// File: rtl/piece_spawner.sv
// piece_spawner: places a tetromino at the top of the playfield RAM after
// checking all four target cells for collision. A collision sets the sticky
// game_over flag instead of writing.
// Ports:
//   clk       in  system clock
//   resetn    in  asynchronous active-low reset
//   bus       slave side of piece_spawner_if (request, status, RAM ports)
//   dbg_state out current FSM state
// Flow: IDLE -> CHECK (4 reads, 5 cycles because of read latency)
//       -> WRITE (4 writes) or OVER -> DONE -> IDLE. An id of 0 goes straight
//       to DONE. All bus outputs are registered and hold when inactive.
module piece_spawner
    import tetris_pkg::*;
#(
    parameter int ROWS      = 20,
    parameter int COLS      = 10,
    parameter int SPAWN_COL = 3,
    parameter int CELL_W    = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    piece_spawner_if.slave       bus,
    output state_t               dbg_state
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    if (COLS < SPAWN_COL + 4 || ROWS < 2) begin : g_bad_params
        $fatal(1, "piece_spawner: illegal ROWS/COLS/SPAWN_COL combination");
    end

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        id_q, id_d;
    logic              coll_q, coll_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              game_over_q, game_over_d;
    logic [RW-1:0]     rd_row_q, rd_row_d;
    logic [CW-1:0]     rd_col_q, rd_col_d;
    logic              wr_en_q, wr_en_d;
    logic [RW-1:0]     wr_row_q, wr_row_d;
    logic [CW-1:0]     wr_col_q, wr_col_d;
    logic [CELL_W-1:0] wr_data_q, wr_data_d;

    logic [2:0]        rom_id;
    logic [1:0]        rom_k;
    logic [RW-1:0]     rom_row;
    logic [CW-1:0]     rom_col;
    logic              coll_now;

    shape_rom #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .SPAWN_COL (SPAWN_COL)
    ) u_shape_rom (
        .id  (rom_id),
        .k   (rom_k),
        .row (rom_row),
        .col (rom_col)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        coll_d      = coll_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        game_over_d = game_over_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        wr_en_d     = wr_en_q;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        wr_data_d   = wr_data_q;
        rom_id      = id_q;
        rom_k       = 2'd0;
        coll_now    = coll_q;

        case (state_q)
            ST_IDLE: begin
                // The ROM looks at the incoming id so cell 0's address can
                // be registered on the acceptance edge.
                rom_id = bus.piece_id;
                if (bus.spawn_req && !game_over_q) begin
                    busy_d = 1'b1;
                    id_d   = bus.piece_id;
                    if (bus.piece_id == PIECE_NONE) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d    = 3'd0;
                        coll_d   = 1'b0;
                        rd_row_d = rom_row;
                        rd_col_d = rom_col;
                        state_d  = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                // cnt 0..3: address of cell cnt is on the bus; data of cell
                // cnt-1 is on rd_data (nothing valid yet when cnt is 0).
                // cnt 4: last datum arrives and the outcome is decided.
                rom_k    = (cnt_q == 3'd4) ? 2'd0 : cnt_q[1:0] + 2'd1;
                coll_now = coll_q | ((cnt_q != 3'd0) && (bus.rd_data != '0));
                coll_d   = coll_now;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q < 3'd3) begin
                    rd_row_d = rom_row;
                    rd_col_d = rom_col;
                end
                if (cnt_q == 3'd4) begin
                    cnt_d = 3'd0;
                    if (coll_now) begin
                        game_over_d = 1'b1;
                        state_d     = ST_OVER;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_row_d  = rom_row;
                        wr_col_d  = rom_col;
                        wr_data_d = CELL_W'(id_q);
                        state_d   = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                // cnt is the cell currently on the write port.
                rom_k = cnt_q[1:0] + 2'd1;
                if (cnt_q == 3'd3) begin
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wr_row_d = rom_row;
                    wr_col_d = rom_col;
                    cnt_d    = cnt_q + 3'd1;
                end
            end

            ST_OVER: begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            id_q        <= 3'd0;
            coll_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            game_over_q <= 1'b0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            coll_q      <= coll_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            game_over_q <= game_over_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            wr_en_q     <= wr_en_d;
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.game_over = game_over_q;
    assign bus.rd_row    = rd_row_q;
    assign bus.rd_col    = rd_col_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_row    = wr_row_q;
    assign bus.wr_col    = wr_col_q;
    assign bus.wr_data   = wr_data_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_piece_spawner.sv
// Testbench for piece_spawner: a default 20x10 instance backed by a
// behavioural playfield RAM, plus an 8x6 instance (SPAWN_COL=1) on an empty
// field. Expectations come from a picture-based shape model and the
// cycle timeline of a request.
module tb_piece_spawner;
    import tetris_pkg::*;

    localparam int ROWS      = 20;
    localparam int COLS      = 10;
    localparam int SPAWN_COL = 3;
    localparam int CELL_W    = 3;

    logic   clk;
    logic   resetn;
    state_t dbg_state;
    state_t dbg_state2;

    piece_spawner_if #(.ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W)) bus ();
    piece_spawner_if #(.ROWS(8), .COLS(6), .CELL_W(3)) bus2 ();

    piece_spawner #(
        .ROWS(ROWS), .COLS(COLS), .SPAWN_COL(SPAWN_COL), .CELL_W(CELL_W)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .dbg_state(dbg_state)
    );

    piece_spawner #(
        .ROWS(8), .COLS(6), .SPAWN_COL(1), .CELL_W(3)
    ) dut2 (
        .clk(clk), .resetn(resetn), .bus(bus2), .dbg_state(dbg_state2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- playfield RAM ----------------
    logic [2:0] ram [0:31][0:15];
    logic       clr_req;
    logic       pre_en;
    int         pre_row;
    int         pre_col;
    logic [2:0] pre_val;

    always @(posedge clk) begin
        if (clr_req) begin
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 16; c++)
                    ram[r][c] <= 3'd0;
        end else if (pre_en) begin
            ram[pre_row][pre_col] <= pre_val;
        end
        if (bus.wr_en) ram[bus.wr_row][bus.wr_col] <= bus.wr_data;
        bus.rd_data <= ram[bus.rd_row][bus.rd_col];
        bus2.rd_data <= 3'd0;
    end

    // ---------------- scoreboard / model state ----------------
    int          n_checks;
    int          n_errors;
    int          ref_field [0:31][0:15];
    int          exp_r [4];
    int          exp_c [4];
    bit          exp_coll;
    logic [15:0] exp_q [$];

    function automatic string shape_pic(input int id);
        case (id)
            1: return "XXXX....";
            2: return "X...XXX.";
            3: return "..X.XXX.";
            4: return ".XX..XX.";
            5: return ".XX.XX..";
            6: return ".X..XXX.";
            7: return "XX...XX.";
            default: return "........";
        endcase
    endfunction

    // Target cells in raster order of the 2x4 picture, and collision
    // against the reference field.
    task automatic model_spawn(input int id, input int scol);
        string pic;
        int    n;
        pic      = shape_pic(id);
        n        = 0;
        exp_coll = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pic[i] == "X") begin
                exp_r[n] = i / 4;
                exp_c[n] = scol + (i % 4);
                if (ref_field[exp_r[n]][exp_c[n]] != 0) exp_coll = 1'b1;
                n++;
            end
        end
    endtask

    task automatic clear_field();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 16; c++)
                ref_field[r][c] = 0;
    endtask

    task automatic preload(input int r, input int c, input int v);
        pre_en  = 1'b1;
        pre_row = r;
        pre_col = c;
        pre_val = 3'(v);
        @(negedge clk);
        pre_en = 1'b0;
        ref_field[r][c] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Issue one request on the main instance and follow it for 14 cycles.
    // extra_k > 0 raises another spawn_req in cycle T+extra_k.
    task automatic run_spawn(input int id, input int extra_k);
        bit          eb, ed, ew, eg;
        logic [15:0] obs;
        logic [15:0] want;
        int          diffs;
        model_spawn(id, SPAWN_COL);
        exp_q.delete();
        if (id != 0 && !exp_coll)
            for (int i = 0; i < 4; i++)
                exp_q.push_back(16'(exp_r[i] * 256 + exp_c[i] * 16 + id));
        @(negedge clk);
        bus.spawn_req = 1'b1;
        bus.piece_id  = 3'(id);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus.spawn_req = (k == extra_k);
            bus.piece_id  = 3'($urandom_range(0, 7));
            if (id == 0) begin
                eb = (k == 1); ed = (k == 1); ew = 1'b0; eg = 1'b0;
            end else if (exp_coll) begin
                eb = (k <= 7); ed = (k == 7); ew = 1'b0; eg = (k >= 6);
            end else begin
                eb = (k <= 10); ed = (k == 10); ew = (k >= 6 && k <= 9); eg = 1'b0;
            end
            n_checks++;
            if ({bus.busy, bus.done, bus.wr_en, bus.game_over} !== {eb, ed, ew, eg}) begin
                n_errors++;
                $display("FAIL status id=%0d k=%0d: busy/done/wr_en/game_over got %b expected %b",
                         id, k, {bus.busy, bus.done, bus.wr_en, bus.game_over}, {eb, ed, ew, eg});
            end
            if (id != 0 && k <= 4) begin
                n_checks++;
                if (int'(bus.rd_row) != exp_r[k-1] || int'(bus.rd_col) != exp_c[k-1]) begin
                    n_errors++;
                    $display("FAIL rd_addr id=%0d k=%0d: got (%0d,%0d) expected (%0d,%0d)",
                             id, k, bus.rd_row, bus.rd_col, exp_r[k-1], exp_c[k-1]);
                end
            end
            if (bus.wr_en) begin
                obs = 16'(int'(bus.wr_row) * 256 + int'(bus.wr_col) * 16 + int'(bus.wr_data));
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL wr_unexpected id=%0d k=%0d: got %h expected no write", id, k, obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want) begin
                        n_errors++;
                        $display("FAIL wr_cell id=%0d k=%0d: got %h expected %h", id, k, obs, want);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL wr_missing id=%0d: got %0d writes short expected 0", id, exp_q.size());
        end
        if (id != 0 && !exp_coll)
            for (int i = 0; i < 4; i++) ref_field[exp_r[i]][exp_c[i]] = id;
        diffs = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (int'(ram[r][c]) != ref_field[r][c]) diffs++;
        n_checks++;
        if (diffs != 0) begin
            n_errors++;
            $display("FAIL field id=%0d: got %0d differing cells expected 0", id, diffs);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.wr_en, bus.game_over} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_status: got %b expected 0000",
                     {bus.busy, bus.done, bus.wr_en, bus.game_over});
        end
        n_checks++;
        if ({bus.rd_row, bus.rd_col, bus.wr_row, bus.wr_col, bus.wr_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_addr: got %h expected 0",
                     {bus.rd_row, bus.rd_col, bus.wr_row, bus.wr_col, bus.wr_data});
        end
        n_checks++;
        if ({bus2.busy, bus2.done, bus2.wr_en, bus2.game_over} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_status2: got %b expected 0000",
                     {bus2.busy, bus2.done, bus2.wr_en, bus2.game_over});
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_invalid();
        run_spawn(0, 0);
        // No read was ever issued, so the read address still holds its reset value.
        n_checks++;
        if ({bus.rd_row, bus.rd_col} !== '0) begin
            n_errors++;
            $display("FAIL invalid_no_read: got (%0d,%0d) expected (0,0)", bus.rd_row, bus.rd_col);
        end
    endtask

    task automatic test_spawn_i();
        clear_field();
        run_spawn(1, 0);
        n_checks++;
        if ({ram[0][3], ram[0][4], ram[0][5], ram[0][6]} !== {3'd1, 3'd1, 3'd1, 3'd1}) begin
            n_errors++;
            $display("FAIL spawn_i_cells: got %h expected 249",
                     {ram[0][3], ram[0][4], ram[0][5], ram[0][6]});
        end
    endtask

    task automatic test_back_to_back_ignored();
        clear_field();
        run_spawn(6, 5);
    endtask

    task automatic test_collision();
        clear_field();
        preload(1, 4, 2);
        run_spawn(4, 0);
        // With game_over set, further requests are dropped.
        @(negedge clk);
        bus.spawn_req = 1'b1;
        bus.piece_id  = 3'd1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.spawn_req = 1'b0;
            n_checks++;
            if ({bus.busy, bus.done, bus.wr_en, bus.game_over} !== 4'b0001) begin
                n_errors++;
                $display("FAIL over_ignored k=%0d: got %b expected 0001",
                         k, {bus.busy, bus.done, bus.wr_en, bus.game_over});
            end
        end
        do_reset();
        n_checks++;
        if (bus.game_over !== 1'b0) begin
            n_errors++;
            $display("FAIL over_cleared: got %b expected 0", bus.game_over);
        end
    endtask

    task automatic test_reset_mid();
        clear_field();
        model_spawn(2, SPAWN_COL);
        @(negedge clk);
        bus.spawn_req = 1'b1;
        bus.piece_id  = 3'd2;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.spawn_req = 1'b0;
        end
        n_checks++;
        if (bus.wr_en !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_wr_active: got %b expected 1", bus.wr_en);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.wr_en, bus.game_over} !== 3'b000) begin
            n_errors++;
            $display("FAIL mid_async_clear: got %b expected 000",
                     {bus.busy, bus.wr_en, bus.game_over});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ram[exp_r[0]][exp_c[0]], ram[exp_r[1]][exp_c[1]]} !== {3'd2, 3'd0}) begin
            n_errors++;
            $display("FAIL mid_partial: got %h expected %h",
                     {ram[exp_r[0]][exp_c[0]], ram[exp_r[1]][exp_c[1]]}, {3'd2, 3'd0});
        end
        clear_field();
        run_spawn(7, 0);
    endtask

    task automatic test_small_field();
        bit eb, ed, ew;
        clear_field();
        model_spawn(3, 1);
        @(negedge clk);
        bus2.spawn_req = 1'b1;
        bus2.piece_id  = 3'd3;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus2.spawn_req = 1'b0;
            eb = (k <= 10); ed = (k == 10); ew = (k >= 6 && k <= 9);
            n_checks++;
            if ({bus2.busy, bus2.done, bus2.wr_en} !== {eb, ed, ew}) begin
                n_errors++;
                $display("FAIL small_status k=%0d: got %b expected %b",
                         k, {bus2.busy, bus2.done, bus2.wr_en}, {eb, ed, ew});
            end
            if (ew) begin
                n_checks++;
                if (int'(bus2.wr_row) != exp_r[k-6] || int'(bus2.wr_col) != exp_c[k-6] ||
                    bus2.wr_data !== 3'd3) begin
                    n_errors++;
                    $display("FAIL small_wr k=%0d: got (%0d,%0d,%0d) expected (%0d,%0d,3)",
                             k, bus2.wr_row, bus2.wr_col, bus2.wr_data, exp_r[k-6], exp_c[k-6]);
                end
            end
        end
    endtask

    task automatic test_random();
        int id;
        int extra_k;
        for (int round = 0; round < 25; round++) begin
            clear_field();
            if ($urandom_range(0, 1) == 1)
                preload($urandom_range(0, 1), $urandom_range(SPAWN_COL, SPAWN_COL + 3),
                        $urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0)
                preload($urandom_range(2, ROWS - 1), $urandom_range(0, COLS - 1),
                        $urandom_range(1, 7));
            id = $urandom_range(0, 7);
            model_spawn(id, SPAWN_COL);
            extra_k = 0;
            if (id != 0 && $urandom_range(0, 1) == 1)
                extra_k = $urandom_range(2, exp_coll ? 7 : 10);
            run_spawn(id, extra_k);
            if (exp_coll) do_reset();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks       = 0;
        n_errors       = 0;
        resetn         = 1'b0;
        clr_req        = 1'b0;
        pre_en         = 1'b0;
        pre_row        = 0;
        pre_col        = 0;
        pre_val        = 3'd0;
        bus.spawn_req  = 1'b0;
        bus.piece_id   = 3'd0;
        bus2.spawn_req = 1'b0;
        bus2.piece_id  = 3'd0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 16; c++)
                ref_field[r][c] = 0;

        test_reset();
        clear_field();
        test_invalid();
        test_spawn_i();
        test_back_to_back_ignored();
        test_collision();
        test_reset_mid();
        test_small_field();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
